// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : reorder_buffer
// Description : In-order retirement buffer. Decode allocates entries at the
//               tail and receives the tag; writeback completes entries by
//               tag in any order; completed entries retire strictly in
//               program order from the head, one per cycle.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               alloc_*            - allocation handshake and returned tag
//               wb_*               - out-of-order result writeback by tag
//               rd_ptr_i/rd_*_o    - combinational operand lookup by tag
//               commit_*           - registered retirement outputs
//               flush_i            - discard all entries
//               count_o            - number of occupied entries
// Revision    : 1.0 - initial release
// ============================================================================
module reorder_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ROB_COUNT  = 32,
    localparam int PW        = $clog2(ROB_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    // allocation
    input  logic                  alloc_valid_i,
    output logic                  alloc_ready_o,
    input  logic                  alloc_has_rd_i,
    input  logic [4:0]            alloc_rd_i,
    output logic [PW-1:0]         alloc_ptr_o,
    // writeback
    input  logic                  wb_valid_i,
    input  logic [PW-1:0]         wb_ptr_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    // operand lookup
    input  logic [PW-1:0]         rd_ptr_i,
    output logic                  rd_ready_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    // commit
    output logic                  commit_valid_o,
    output logic                  commit_wr_en_o,
    output logic [4:0]            commit_rd_o,
    output logic [DATA_WIDTH-1:0] commit_data_o,
    output logic [PW-1:0]         commit_ptr_o,
    // control / status
    input  logic                  flush_i,
    output logic [PW:0]           count_o
);

    localparam logic [PW:0]   c_full_count = (PW+1)'(ROB_COUNT);
    localparam logic [PW-1:0] c_ptr_one    = PW'(1);
    localparam logic [PW:0]   c_count_one  = (PW+1)'(1);

    // Per-entry state. Only valid/done carry reset; payload fields are
    // always rewritten before they can be observed.
    logic [ROB_COUNT-1:0]  r_valid;
    logic [ROB_COUNT-1:0]  r_done;
    logic [ROB_COUNT-1:0]  r_has_rd;
    logic [4:0]            r_rd   [ROB_COUNT];
    logic [DATA_WIDTH-1:0] r_data [ROB_COUNT];

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]   r_count;

    logic w_alloc;
    logic w_commit;
    logic w_wb;

    // Full is judged from the registered count only, so a retirement in the
    // same cycle never frees a slot for an allocation.
    assign alloc_ready_o = (r_count != c_full_count);
    assign alloc_ptr_o   = r_tail;
    assign count_o       = r_count;

    assign w_alloc  = alloc_valid_i & alloc_ready_o;
    assign w_commit = r_valid[r_head] & r_done[r_head];
    assign w_wb     = wb_valid_i & r_valid[wb_ptr_i];

    // Lookup sees registered state only; a same-cycle writeback is not
    // forwarded.
    assign rd_ready_o = r_valid[rd_ptr_i] & r_done[rd_ptr_i];
    assign rd_data_o  = r_data[rd_ptr_i];

    // Payload storage. A valid writeback can never target the tail slot
    // being allocated (the tail slot is always invalid while not full), so
    // the two writes never collide.
    always_ff @(posedge clk) begin
        if (!rst && !flush_i) begin
            if (w_wb) begin
                r_data[wb_ptr_i] <= wb_data_i;
            end
            if (w_alloc) begin
                r_has_rd[r_tail] <= alloc_has_rd_i;
                r_rd[r_tail]     <= alloc_rd_i;
            end
        end
    end

    // Control state and registered commit outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid        <= '0;
            r_done         <= '0;
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            commit_valid_o <= 1'b0;
            commit_wr_en_o <= 1'b0;
            commit_rd_o    <= '0;
            commit_data_o  <= '0;
            commit_ptr_o   <= '0;
        end else if (flush_i) begin
            // Commit payload outputs keep their last values across a flush.
            r_valid        <= '0;
            r_done         <= '0;
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            commit_valid_o <= 1'b0;
            commit_wr_en_o <= 1'b0;
        end else begin
            commit_valid_o <= w_commit;
            commit_wr_en_o <= w_commit & r_has_rd[r_head];

            if (w_commit) begin
                commit_rd_o     <= r_rd[r_head];
                commit_data_o   <= r_data[r_head];
                commit_ptr_o    <= r_head;
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + c_ptr_one;
            end

            // A writeback to the retiring head is allowed; that entry goes
            // invalid, so its stale done bit is harmless and is cleared
            // again on reallocation.
            if (w_wb) begin
                r_done[wb_ptr_i] <= 1'b1;
            end

            // Head and tail can only coincide here when the buffer is empty
            // (no commit) or full (no allocation), so these never collide.
            if (w_alloc) begin
                r_valid[r_tail] <= 1'b1;
                r_done[r_tail]  <= 1'b0;
                r_tail          <= r_tail + c_ptr_one;
            end

            if (w_alloc && !w_commit) begin
                r_count <= r_count + c_count_one;
            end else if (!w_alloc && w_commit) begin
                r_count <= r_count - c_count_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reorder_buffer
// Description : Self-checking bench for reorder_buffer. A queue of in-flight
//               instructions in program order serves as reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reorder_buffer;

    localparam int DW = 32;
    localparam int N  = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          alloc_valid_i = 1'b0;
    logic          alloc_ready_o;
    logic          alloc_has_rd_i = 1'b0;
    logic [4:0]    alloc_rd_i = '0;
    logic [4:0]    alloc_ptr_o;
    logic          wb_valid_i = 1'b0;
    logic [4:0]    wb_ptr_i = '0;
    logic [DW-1:0] wb_data_i = '0;
    logic [4:0]    rd_ptr_i = '0;
    logic          rd_ready_o;
    logic [DW-1:0] rd_data_o;
    logic          commit_valid_o;
    logic          commit_wr_en_o;
    logic [4:0]    commit_rd_o;
    logic [DW-1:0] commit_data_o;
    logic [4:0]    commit_ptr_o;
    logic          flush_i = 1'b0;
    logic [5:0]    count_o;

    always #5 clk = ~clk;

    reorder_buffer #(.DATA_WIDTH(DW), .ROB_COUNT(N)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
        .alloc_has_rd_i(alloc_has_rd_i), .alloc_rd_i(alloc_rd_i),
        .alloc_ptr_o(alloc_ptr_o),
        .wb_valid_i(wb_valid_i), .wb_ptr_i(wb_ptr_i), .wb_data_i(wb_data_i),
        .rd_ptr_i(rd_ptr_i), .rd_ready_o(rd_ready_o), .rd_data_o(rd_data_o),
        .commit_valid_o(commit_valid_o), .commit_wr_en_o(commit_wr_en_o),
        .commit_rd_o(commit_rd_o), .commit_data_o(commit_data_o),
        .commit_ptr_o(commit_ptr_o),
        .flush_i(flush_i), .count_o(count_o)
    );

    // ---------------- reference model ----------------
    typedef struct {
        int          tag;
        logic        has_rd;
        logic [4:0]  rd;
        logic        done;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    int          m_next_tag = 0;
    logic        m_cv = 1'b0;
    logic        m_cwe = 1'b0;
    logic [4:0]  m_crd = '0;
    logic [31:0] m_cdata = '0;
    int          m_cptr = 0;

    int n_checks = 0;
    int n_pass   = 0;

    // Applies one clock edge to the model, using the inputs as driven.
    function automatic void model_update();
        ent_t e;
        logic com;
        logic full;
        if (rst) begin
            q.delete();
            m_next_tag = 0;
            m_cv = 1'b0; m_cwe = 1'b0; m_crd = '0; m_cdata = '0; m_cptr = 0;
        end else if (flush_i) begin
            q.delete();
            m_next_tag = 0;
            m_cv = 1'b0; m_cwe = 1'b0;
        end else begin
            full = (q.size() == N);
            com  = (q.size() > 0) && q[0].done;
            if (com) begin
                m_cv = 1'b1; m_cwe = q[0].has_rd; m_crd = q[0].rd;
                m_cdata = q[0].data; m_cptr = q[0].tag;
            end else begin
                m_cv = 1'b0; m_cwe = 1'b0;
            end
            if (wb_valid_i) begin
                foreach (q[i]) begin
                    if (q[i].tag == int'(wb_ptr_i)) begin
                        e = q[i]; e.done = 1'b1; e.data = wb_data_i; q[i] = e;
                    end
                end
            end
            if (com) void'(q.pop_front());
            if (alloc_valid_i && !full) begin
                e.tag = m_next_tag; e.has_rd = alloc_has_rd_i; e.rd = alloc_rd_i;
                e.done = 1'b0; e.data = '0;
                q.push_back(e);
                m_next_tag = (m_next_tag + 1) % N;
            end
        end
    endfunction

    function automatic void model_lookup(input int p, output logic rdy, output logic [31:0] d);
        rdy = 1'b0; d = '0;
        foreach (q[i]) begin
            if (q[i].tag == p && q[i].done) begin
                rdy = 1'b1; d = q[i].data;
            end
        end
    endfunction

    // Drives one cycle of inputs (from a negedge), advances model and DUT
    // by one edge, and returns at the following negedge.
    task automatic tick(input logic a, input logic hr, input logic [4:0] rd,
                        input logic wv, input logic [4:0] wp, input logic [31:0] wd,
                        input logic fl);
        alloc_valid_i = a; alloc_has_rd_i = hr; alloc_rd_i = rd;
        wb_valid_i = wv; wb_ptr_i = wp; wb_data_i = wd; flush_i = fl;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    task automatic do_flush();
        tick(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 32'd0, 1'b0);
        tick(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 32'd0, 1'b0);
        rst = 1'b0;
        alloc_valid_i = 1'b0;
        rd_ptr_i = 5'd0;
        #1;
        n_checks++; if (count_o !== 6'd0) $display("FAIL reset_count: got %0d want 0", count_o); else n_pass++;
        n_checks++; if (alloc_ptr_o !== 5'd0) $display("FAIL reset_alloc_ptr: got %0d want 0", alloc_ptr_o); else n_pass++;
        n_checks++; if (alloc_ready_o !== 1'b1) $display("FAIL reset_alloc_ready: got %b want 1", alloc_ready_o); else n_pass++;
        n_checks++; if (commit_valid_o !== 1'b0) $display("FAIL reset_commit_valid: got %b want 0", commit_valid_o); else n_pass++;
        n_checks++; if (commit_ptr_o !== 5'd0 || commit_rd_o !== 5'd0 || commit_data_o !== 32'd0)
            $display("FAIL reset_commit_fields: got ptr=%0d rd=%0d data=%h want 0/0/0", commit_ptr_o, commit_rd_o, commit_data_o);
        else n_pass++;
        n_checks++; if (rd_ready_o !== 1'b0) $display("FAIL reset_rd_ready: got %b want 0", rd_ready_o); else n_pass++;
    endtask

    task automatic test_fill();
        int perm[N];
        int j, t;
        for (int i = 0; i < N; i++) begin
            n_checks++; if (alloc_ptr_o !== 5'(i) || alloc_ready_o !== 1'b1)
                $display("FAIL fill_tag: got ptr=%0d ready=%b want ptr=%0d ready=1", alloc_ptr_o, alloc_ready_o, i);
            else n_pass++;
            tick(1'b1, 1'($urandom), 5'($urandom), 1'b0, 5'd0, 32'd0, 1'b0);
        end
        n_checks++; if (count_o !== 6'd32 || alloc_ready_o !== 1'b0)
            $display("FAIL fill_full: got count=%0d ready=%b want 32/0", count_o, alloc_ready_o);
        else n_pass++;
        tick(1'b1, 1'b1, 5'd1, 1'b0, 5'd0, 32'd0, 1'b0);
        n_checks++; if (count_o !== 6'd32 || alloc_ptr_o !== 5'd0)
            $display("FAIL fill_overflow: got count=%0d ptr=%0d want 32/0", count_o, alloc_ptr_o);
        else n_pass++;
        // complete all entries in a shuffled order, then let them drain
        for (int i = 0; i < N; i++) perm[i] = i;
        for (int i = N - 1; i > 0; i--) begin
            j = $urandom_range(i, 0); t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        for (int i = 0; i < N + 40; i++) begin
            if (i < N) tick(1'b0, 1'b0, 5'd0, 1'b1, 5'(perm[i]), $urandom, 1'b0);
            else idle();
            n_checks++; if (commit_valid_o !== m_cv || (m_cv && (commit_ptr_o !== 5'(m_cptr) || commit_data_o !== m_cdata)))
                $display("FAIL fill_drain: got v=%b ptr=%0d data=%h want v=%b ptr=%0d data=%h",
                         commit_valid_o, commit_ptr_o, commit_data_o, m_cv, m_cptr, m_cdata);
            else n_pass++;
            if (i >= N && q.size() == 0 && !m_cv) break;
        end
        n_checks++; if (count_o !== 6'd0) $display("FAIL fill_drained_count: got %0d want 0", count_o); else n_pass++;
    endtask

    task automatic test_out_of_order();
        do_flush();
        tick(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 32'd0, 1'b0);
        tick(1'b1, 1'b1, 5'd6, 1'b0, 5'd0, 32'd0, 1'b0);
        tick(1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 32'd0, 1'b0);
        alloc_valid_i = 1'b0;
        tick(1'b0, 1'b0, 5'd0, 1'b1, 5'd2, 32'hC, 1'b0);
        rd_ptr_i = 5'd2; #1;
        n_checks++; if (rd_ready_o !== 1'b1 || rd_data_o !== 32'hC)
            $display("FAIL ooo_lookup: got ready=%b data=%h want 1/c", rd_ready_o, rd_data_o);
        else n_pass++;
        tick(1'b0, 1'b0, 5'd0, 1'b1, 5'd1, 32'hB, 1'b0);
        tick(1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 32'hA, 1'b0);
        n_checks++; if (commit_valid_o !== 1'b0) $display("FAIL ooo_early_commit: got %b want 0", commit_valid_o); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            idle();
            n_checks++; if (commit_valid_o !== 1'b1 || commit_wr_en_o !== 1'b1 || commit_ptr_o !== 5'(k) ||
                            commit_rd_o !== 5'(5 + k) || commit_data_o !== 32'(10 + k))
                $display("FAIL ooo_commit%0d: got v=%b we=%b ptr=%0d rd=%0d data=%h want 1/1/%0d/%0d/%h",
                         k, commit_valid_o, commit_wr_en_o, commit_ptr_o, commit_rd_o, commit_data_o, k, 5 + k, 10 + k);
            else n_pass++;
        end
        idle();
        n_checks++; if (commit_valid_o !== 1'b0 || count_o !== 6'd0)
            $display("FAIL ooo_after: got v=%b count=%0d want 0/0", commit_valid_o, count_o);
        else n_pass++;
    endtask

    task automatic test_no_rd();
        logic [4:0] tag;
        tag = alloc_ptr_o;
        tick(1'b1, 1'b0, 5'd9, 1'b0, 5'd0, 32'd0, 1'b0);
        tick(1'b0, 1'b0, 5'd0, 1'b1, tag, 32'h1234, 1'b0);
        idle();
        n_checks++; if (commit_valid_o !== 1'b1 || commit_wr_en_o !== 1'b0 || commit_ptr_o !== tag)
            $display("FAIL no_rd: got v=%b we=%b ptr=%0d want 1/0/%0d", commit_valid_o, commit_wr_en_o, commit_ptr_o, tag);
        else n_pass++;
    endtask

    task automatic test_wrap_steady();
        logic seen31;
        logic wrapped;
        seen31 = 1'b0; wrapped = 1'b0;
        do_flush();
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 5'(i), 1'b0, 5'd0, 32'd0, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 5'd0, 1'b1, 5'(i), $urandom, 1'b0);
        for (int i = 0; i < 10 && count_o != 6'd0; i++) idle();
        for (int i = 0; i < 31; i++) tick(1'b1, 1'b1, 5'($urandom), 1'b0, 5'd0, 32'd0, 1'b0);
        tick(1'b0, 1'b0, 5'd0, 1'b1, 5'd5, $urandom, 1'b0);
        n_checks++; if (count_o !== 6'd31 || alloc_ptr_o !== 5'd4)
            $display("FAIL wrap_setup: got count=%0d ptr=%0d want 31/4", count_o, alloc_ptr_o);
        else n_pass++;
        for (int k = 0; k < 40; k++) begin
            n_checks++; if (alloc_ptr_o !== 5'((4 + k) % N) || alloc_ready_o !== 1'b1)
                $display("FAIL wrap_alloc_ptr: got %0d ready=%b want %0d ready=1", alloc_ptr_o, alloc_ready_o, (4 + k) % N);
            else n_pass++;
            if (alloc_ptr_o == 5'd31) seen31 = 1'b1;
            else if (seen31 && alloc_ptr_o == 5'd0) wrapped = 1'b1;
            tick(1'b1, 1'($urandom), 5'($urandom), 1'b1, 5'((6 + k) % N), $urandom, 1'b0);
            n_checks++; if (count_o !== 6'd31 || commit_valid_o !== 1'b1 || commit_ptr_o !== 5'((5 + k) % N) ||
                            commit_data_o !== m_cdata || commit_rd_o !== m_crd || commit_wr_en_o !== m_cwe)
                $display("FAIL wrap_steady: got count=%0d v=%b ptr=%0d data=%h want 31/1/%0d/%h",
                         count_o, commit_valid_o, commit_ptr_o, commit_data_o, (5 + k) % N, m_cdata);
            else n_pass++;
        end
        n_checks++; if (wrapped !== 1'b1) $display("FAIL wrap_seen: got %b want 1", wrapped); else n_pass++;
    endtask

    task automatic test_flush();
        do_flush();
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 5'(i), 1'b0, 5'd0, 32'd0, 1'b0);
        tick(1'b0, 1'b0, 5'd0, 1'b1, 5'd3, 32'h33, 1'b0);
        tick(1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 32'h55, 1'b1);
        n_checks++; if (commit_valid_o !== 1'b0 || count_o !== 6'd0 || alloc_ptr_o !== 5'd0 || alloc_ready_o !== 1'b1)
            $display("FAIL flush_state: got v=%b count=%0d ptr=%0d ready=%b want 0/0/0/1",
                     commit_valid_o, count_o, alloc_ptr_o, alloc_ready_o);
        else n_pass++;
        idle();
        n_checks++; if (commit_valid_o !== 1'b0) $display("FAIL flush_no_commit: got %b want 0", commit_valid_o); else n_pass++;
        for (int t = 1; t <= 3; t++) begin
            tick(1'b0, 1'b0, 5'd0, 1'b1, 5'(t), 32'hDEAD, 1'b0);
            rd_ptr_i = 5'(t); #1;
            n_checks++; if (rd_ready_o !== 1'b0 || commit_valid_o !== 1'b0)
                $display("FAIL flush_stale_wb%0d: got ready=%b v=%b want 0/0", t, rd_ready_o, commit_valid_o);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic       a, wv, fl, rdy;
        logic [4:0] wp;
        logic [31:0] d;
        do_flush();
        for (int c = 0; c < 600; c++) begin
            a  = ($urandom % 10) < 6;
            wv = ($urandom % 10) < 7;
            if (q.size() > 0 && ($urandom % 4) != 0) wp = 5'(q[$urandom_range(q.size() - 1, 0)].tag);
            else wp = 5'($urandom);
            fl = ($urandom % 80) == 0;
            n_checks++; if (alloc_ready_o !== (q.size() < N) || alloc_ptr_o !== 5'(m_next_tag))
                $display("FAIL rand_alloc: got ready=%b ptr=%0d want %b/%0d", alloc_ready_o, alloc_ptr_o, q.size() < N, m_next_tag);
            else n_pass++;
            tick(a, 1'($urandom), 5'($urandom), wv, wp, $urandom, fl);
            n_checks++; if (commit_valid_o !== m_cv || commit_wr_en_o !== m_cwe || commit_ptr_o !== 5'(m_cptr) ||
                            commit_rd_o !== m_crd || commit_data_o !== m_cdata || count_o !== 6'(q.size()))
                $display("FAIL rand_commit: got v=%b we=%b ptr=%0d rd=%0d data=%h cnt=%0d want %b/%b/%0d/%0d/%h/%0d",
                         commit_valid_o, commit_wr_en_o, commit_ptr_o, commit_rd_o, commit_data_o, count_o,
                         m_cv, m_cwe, m_cptr, m_crd, m_cdata, q.size());
            else n_pass++;
            rd_ptr_i = 5'($urandom); #1;
            model_lookup(int'(rd_ptr_i), rdy, d);
            n_checks++; if (rd_ready_o !== rdy || (rdy && rd_data_o !== d))
                $display("FAIL rand_lookup: tag %0d got ready=%b data=%h want %b/%h", rd_ptr_i, rd_ready_o, rd_data_o, rdy, d);
            else n_pass++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_fill();
        test_out_of_order();
        test_no_rd();
        test_wrap_steady();
        test_flush();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reorder_buffer.md
# reorder_buffer

In-order retirement buffer for the out-of-order core, sitting between decode, writeback and commit. Decode allocates one entry per instruction and receives its ROB tag, which goes to the rename table. Writeback deposits results by tag in any order. The buffer retires completed entries strictly in program order, producing architectural register-file writes and tags that let the rename table clear pending mappings.

## Interface
Parameters:
- DATA_WIDTH, 32, result width
- ROB_COUNT, 32, entry count; must be a power of two, minimum 4; PW = $clog2(ROB_COUNT)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- alloc_valid_i  in  1  decode requests an entry
- alloc_ready_o  out  1  entry available
- alloc_has_rd_i  in  1  instruction writes a destination register
- alloc_rd_i  in  5  destination ARF index
- alloc_ptr_o  out  PW  tag the entry will receive (current tail)
- wb_valid_i  in  1  writeback result valid
- wb_ptr_i  in  PW  tag being completed
- wb_data_i  in  DATA_WIDTH  result
- rd_ptr_i  in  PW  operand lookup tag (from rename table)
- rd_ready_o  out  1  looked-up entry valid and done
- rd_data_o  out  DATA_WIDTH  looked-up result
- commit_valid_o  out  1  one entry retired (one-cycle pulse)
- commit_wr_en_o  out  1  ARF write enable (commit_valid_o AND entry has_rd)
- commit_rd_o  out  5  ARF index
- commit_data_o  out  DATA_WIDTH  ARF write data
- commit_ptr_o  out  PW  retired tag (rename table clears pending if mapping matches)
- flush_i  in  1  discard all entries
- count_o  out  PW+1  occupied entries

## Operation
- Entry fields: valid, done, has_rd, rd[4:0], data. Circular buffer with head, tail (PW bits, natural wrap) and count (PW+1 bits).
- Allocation: handshake = alloc_valid_i & alloc_ready_o. On handshake, entry[tail] is written with valid=1, done=0, has_rd, rd; tail+1; count+1. alloc_ready_o = (count != ROB_COUNT), computed from registered count only, so no allocation is accepted when full, even in a cycle with a commit.
- Writeback: if wb_valid_i and entry[wb_ptr_i].valid, set done and write data. Writeback to an invalid entry is ignored. Writeback to an already-done entry overwrites the data.
- Commit: if entry[head].valid & done, clear valid, advance head+1, count-1, and register the commit_* outputs from that entry. Otherwise commit_valid_o and commit_wr_en_o are 0 next cycle; the other commit_* outputs hold their previous values. At most one commit per cycle.
- Allocate and commit in the same cycle: count is unchanged; both pointers advance.
- Lookup: combinational. rd_ready_o = entry[rd_ptr_i].valid & done; rd_data_o = entry[rd_ptr_i].data. There is no bypass of a same-cycle writeback.
- Flush: all valid and done bits, head, tail and count are cleared; commit_valid_o and commit_wr_en_o are 0 next cycle. Flush overrides allocate, writeback and commit in the same cycle.
- Reset: same effect as flush. Also, commit_rd_o=0, commit_data_o=0 and commit_ptr_o=0. alloc_ready_o=1, alloc_ptr_o=0, count_o=0 and rd_ready_o=0 after reset. Entry data and rd are not reset.

## Timing
- alloc_ptr_o and alloc_ready_o are valid combinationally in the cycle of the request. The tag is consumed at the handshake edge.
- Writeback sampled at edge E sets done after E. The head entry retires at edge E+1, and commit_valid_o is high in the cycle after E+1. Minimum allocate-to-commit latency is therefore 2 edges after writeback.
- Sustained throughput is 1 allocate plus 1 commit per cycle.
- rd_ready_o reflects a writeback one cycle after the writeback edge.
- Pointer wrap: tag ROB_COUNT-1 is followed by tag 0, and full/empty are distinguished only by count.

## Test plan
- Reset: assert rst for 2 cycles with alloc_valid_i=1 -> count_o=0, alloc_ptr_o=0, alloc_ready_o=1, commit_valid_o=0 and no entry allocated.
- Fill: 32 back-to-back allocations with no writeback -> tags 0..31 issued, count_o=32, alloc_ready_o=0; a 33rd request is not accepted, and tail and count are unchanged.
- Out-of-order completion: allocate tags 0,1,2 (rd=5,6,7); write back tag 2 (data 0xC), then tag 1 (0xB), then tag 0 (0xA) -> commits tag0/rd5/0xA, tag1/rd6/0xB and tag2/rd7/0xC on three consecutive cycles after tag 0 completes.
- No-destination instruction: allocate with has_rd=0 and write back -> commit_valid_o=1 and commit_wr_en_o=0.
- Wrap and steady state: at count=31 with head=5, do simultaneous allocate and commit for 40 cycles -> count stays 31, alloc_ptr_o wraps from 31 to 0, and commits appear in tag order.
- Flush: 10 entries outstanding, flush_i asserted in the same cycle as a writeback to the head entry -> no commit pulse, count_o=0, alloc_ptr_o=0; later writebacks to the old tags are ignored (rd_ready_o=0).
